// File: rtl/phase_ramp_generator_if.sv
// phase_ramp_generator_if: phase sample stream toward the sine stage (valid/ready)
interface phase_ramp_generator_if;
  logic [15:0] phase_out;
  logic        phase_valid;
  logic        phase_ready;
  modport master (output phase_out, output phase_valid, input phase_ready);
  modport slave  (input phase_out, input phase_valid, output phase_ready);
endinterface

// File: rtl/phase_ramp_generator.sv
// phase_ramp_generator: burst tone/chirp phase source; a 32-bit accumulator whose
// top 16 bits (65536 = 2*pi) are streamed to the sine stage over valid/ready.
module phase_ramp_generator #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [15:0]          phase_init,
  input  logic [ACC_W-1:0]     freq_start,
  input  logic [ACC_W-1:0]     freq_step,
  input  logic [CNT_W-1:0]     num_samples,
  phase_ramp_generator_if.master ph,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q;
  logic [ACC_W-1:0]   acc_q, freq_q, step_q, acc_d;
  logic [CNT_W-1:0]   rem_q;
  logic [15:0]        phase_q;
  logic               valid_q, busy_q, done_q, fire;
  assign acc_d          = acc_q + freq_q;
  assign fire           = valid_q && ph.phase_ready;
  assign ph.phase_out   = phase_q;
  assign ph.phase_valid = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  // phase_q tracks acc_q's top bits as a register so the output never glitches
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      freq_q  <= '0;
      step_q  <= '0;
      rem_q   <= '0;
      phase_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            acc_q   <= {phase_init, {(ACC_W-16){1'b0}}};
            freq_q  <= freq_start;
            step_q  <= freq_step;
            rem_q   <= num_samples;
            phase_q <= phase_init;
            if (num_samples != '0) begin
              state_q <= RUN;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
          RUN: if (fire) begin
            acc_q   <= acc_d;
            freq_q  <= freq_q + step_q;
            rem_q   <= rem_q - CNT_W'(1);
            phase_q <= acc_d[ACC_W-1 -: 16];
            if (rem_q == CNT_W'(1)) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_phase_ramp_generator.sv
// tb_phase_ramp_generator: closed-form phase model checked every cycle, directed
// scenarios pinned with literal sequences, then randomized start/abort/ready traffic.
module tb_phase_ramp_generator;
  logic        clock = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] phase_init = '0, num_samples = '0;
  logic [31:0] freq_start = '0, freq_step = '0;
  logic        busy, done;
  phase_ramp_generator_if pif();
  phase_ramp_generator #(.ACC_W(32), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .phase_init(phase_init), .freq_start(freq_start), .freq_step(freq_step),
    .num_samples(num_samples), .ph(pif), .busy(busy), .done(done)
  );
  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  int ms = 0, m_n = 0, m_k = 0;
  logic [15:0] m_init = '0, m_phase = '0;
  logic [31:0] m_f0 = '0, m_st = '0;
  logic [15:0] seen[$], want[$];
  int busy_cnt = 0, done_cnt = 0;

  // phase after k accepted samples: init + k*f0 + k(k-1)/2*step, mod 2^32
  function automatic logic [15:0] ph_of(int k);
    logic [63:0] a;
    a = {32'h0, m_init, 16'h0} + 64'(k) * 64'(m_f0) + ((64'(k) * 64'(k - 1)) / 2) * 64'(m_st);
    return a[31:16];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!reset_n) begin
      ms = 0;
      m_phase = '0;
    end else if (abort) ms = 0;
    else if (ms == 0) begin
      if (start) begin
        m_init = phase_init; m_f0 = freq_start; m_st = freq_step;
        m_n = int'(num_samples); m_k = 0; m_phase = phase_init;
        ms = (m_n != 0) ? 1 : 2;
      end
    end else if (ms == 1) begin
      if (pif.phase_ready) begin
        m_k++;
        m_phase = ph_of(m_k);
        if (m_k == m_n) ms = 2;
      end
    end else ms = 0;
  endtask

  task automatic cyc();
    if (pif.phase_valid && pif.phase_ready) seen.push_back(pif.phase_out);
    @(posedge clock);
    model_step();
    #1;
    chk("valid", pif.phase_valid, ms == 1);
    chk("busy", busy, ms == 1);
    chk("done", done, ms == 2);
    if (ms == 1) chk("phase", pif.phase_out, m_phase);
    busy_cnt += int'(busy);
    done_cnt += int'(done);
  endtask

  task automatic burst(logic [15:0] init, logic [31:0] f0, logic [31:0] st, logic [15:0] n);
    phase_init = init; freq_start = f0; freq_step = st; num_samples = n;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_until_idle(int lim);
    int i = 0;
    while (ms != 0 && i < lim) begin
      cyc();
      i++;
    end
    chk("idle_timeout", ms, 0);
  endtask

  task automatic chk_seq(string name);
    chk({name, "_len"}, seen.size(), want.size());
    for (int i = 0; i < want.size() && i < seen.size(); i++) chk(name, seen[i], want[i]);
  endtask

  task automatic clear_stats();
    seen.delete(); busy_cnt = 0; done_cnt = 0;
  endtask

  task automatic async_reset();
    #3 reset_n = 1'b0;
    #1;
    chk("rst_valid", pif.phase_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_phase", pif.phase_out, 0);
    cyc();
    #2 reset_n = 1'b1;
  endtask

  initial begin
    pif.phase_ready = 1'b1;
    #12;
    chk("por_valid", pif.phase_valid, 0);
    chk("por_busy", busy, 0);
    chk("por_phase", pif.phase_out, 0);
    reset_n = 1'b1;
    repeat (3) cyc();

    clear_stats();
    burst(16'h0, 32'h4000_0000, 32'h0, 16'd5);
    chk("tone_first_valid", pif.phase_valid, 1);
    chk("tone_first_phase", pif.phase_out, 0);
    run_until_idle(20);
    cyc();
    want = {16'd0, 16'd16384, 16'd32768, 16'd49152, 16'd0};
    chk_seq("tone_seq");
    chk("tone_busy_cycles", busy_cnt, 5);
    chk("tone_done_pulses", done_cnt, 1);

    begin
      int held = 0, i = 0;
      clear_stats();
      burst(16'h0, 32'h4000_0000, 32'h0, 16'd5);
      while (ms != 0 && i < 30) begin
        if (pif.phase_valid && pif.phase_out == 16'd32768 && held < 3) begin
          pif.phase_ready = 1'b0;
          held++;
        end else pif.phase_ready = 1'b1;
        cyc();
        if (!pif.phase_ready) chk("bp_hold", {pif.phase_valid, pif.phase_out}, {1'b1, 16'd32768});
        i++;
      end
      pif.phase_ready = 1'b1;
      cyc();
      chk("bp_stalls", held, 3);
      chk_seq("bp_seq");
      chk("bp_done_pulses", done_cnt, 1);
    end

    clear_stats();
    burst(16'hFFFF, 32'h0001_0000, 32'h0001_0000, 16'd4);
    run_until_idle(20);
    want = {16'hFFFF, 16'h0000, 16'h0002, 16'h0005};
    chk_seq("chirp_seq");

    clear_stats();
    burst(16'h1234, 32'h10, 32'h0, 16'd0);
    chk("empty_done", done, 1);
    chk("empty_valid", pif.phase_valid, 0);
    cyc();
    chk("empty_done_drop", done, 0);
    chk("empty_busy_cycles", busy_cnt, 0);

    clear_stats();
    burst(16'h0, 32'h4000_0000, 32'h0, 16'd6);
    phase_init = 16'h1234; num_samples = 16'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    pif.phase_ready = 1'b0; abort = 1'b1;
    cyc();
    abort = 1'b0; pif.phase_ready = 1'b1;
    chk("abort_valid", pif.phase_valid, 0);
    repeat (3) cyc();
    want = {16'd0, 16'd16384};
    chk_seq("abort_seq");
    chk("abort_no_done", done_cnt, 0);
    clear_stats();
    burst(16'h0, 32'h4000_0000, 32'h0, 16'd3);
    run_until_idle(20);
    want = {16'd0, 16'd16384, 16'd32768};
    chk_seq("restart_seq");
    chk("restart_done", done_cnt, 1);

    clear_stats();
    burst(16'h0100, 32'h0123_4567, 32'h0000_1000, 16'd8);
    repeat (2) cyc();
    async_reset();
    repeat (3) cyc();
    chk("midrst_no_done", done_cnt, 0);

    for (int i = 0; i < 400; i++) begin
      pif.phase_ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 29) == 0);
      phase_init = 16'($urandom);
      freq_start = $urandom;
      freq_step = $urandom;
      num_samples = 16'($urandom_range(0, 7));
      cyc();
    end
    start = 1'b0; abort = 1'b0; pif.phase_ready = 1'b1;
    run_until_idle(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/phase_ramp_generator.md
Name: phase_ramp_generator

Overview:
Sample-rate phase source that feeds the polynomial_approximation sine stage's 16-bit x input. The phase scale is 65536 = 2π, so 16384 = π/2 and 32768 = π. It generates a programmable burst of phase samples, either a constant-frequency tone or a linear chirp used for qubit-movement tones, through a 32-bit phase accumulator. The top 16 bits are presented to the sine stage over a valid/ready handshake.

Parameters:
ACC_W, 32, phase/frequency accumulator width; output phase is acc[ACC_W-1:ACC_W-16]
CNT_W, 16, sample-count width

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; launches a burst when idle
abort  input  1  one-cycle pulse; terminates a burst immediately
phase_init  input  16  initial phase, loaded into acc[ACC_W-1:ACC_W-16]; lower acc bits cleared
freq_start  input  ACC_W  initial per-sample phase increment, two's complement, modulo 2^ACC_W
freq_step  input  ACC_W  per-sample increment added to frequency (chirp rate), two's complement
num_samples  input  CNT_W  samples in burst; 0 = empty burst
phase_out  output  16  phase sample to sine stage (x)
phase_valid  output  1  phase_out valid
phase_ready  input  1  downstream accepts sample
busy  output  1  burst in progress (RUN state)
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset (async assert, sync release): state IDLE; acc, freq, remaining = 0; phase_out = 0; phase_valid = 0; busy = 0; done = 0. All outputs are registered.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1, abort=0:
  - Latch acc = {phase_init, 0}, freq = freq_start, freq_step, remaining = num_samples.
  - Go to RUN if num_samples != 0, else go to DONE.
  - Config inputs are sampled only on this cycle.
- Latency: start sampled at edge N; phase_valid = 1 and phase_out = phase_init are visible after edge N+1, i.e. on the first cycle of RUN.
- RUN:
  - phase_valid = 1, busy = 1, phase_out = acc[ACC_W-1:ACC_W-16].
  - Handshake (phase_valid && phase_ready):
    - acc <= acc + freq (wraps modulo 2^ACC_W, no saturation).
    - freq <= freq + freq_step (wraps).
    - remaining <= remaining - 1.
    - If remaining == 1, go to DONE and drop phase_valid on the next cycle.
  - No handshake: acc, freq, remaining and phase_out are held stable. phase_valid must not drop until the sample is accepted or abort occurs.
- DONE: done = 1 for exactly one cycle; valid = 0, busy = 0; next state IDLE.
- Throughput: one sample per cycle while phase_ready = 1. No bubbles between samples.
- start while in RUN or DONE: ignored, no effect.
- abort (any state): next state IDLE; phase_valid, busy, done = 0 on the next cycle; no done pulse. abort wins over a simultaneous start or a simultaneous final handshake.
- phase_out truncates lower accumulator bits; no rounding.
- Reset asserted mid-burst: immediate return to reset values; no done pulse.

Test Plan:
- Reset: assert reset_n=0 mid-clock -> phase_valid=0, busy=0, done=0, phase_out=0 asynchronously; after release, nothing happens until start.
- Constant tone: phase_init=0, freq_start=0x4000_0000, freq_step=0, num_samples=5, ready=1 -> phase_out 0, 16384, 32768, 49152, 0 on consecutive cycles; done pulse one cycle after the 5th handshake; busy high for exactly 5 cycles.
- Backpressure: same burst, phase_ready=0 for 3 cycles while phase_out=32768 -> phase_out held at 32768 with valid high; sequence then resumes at 49152; total handshakes = 5.
- Chirp and wrap: phase_init=0xFFFF, freq_start=0x0001_0000, freq_step=0x0001_0000, num_samples=4 -> phase_out 0xFFFF, 0x0000, 0x0002, 0x0005.
- Empty burst: num_samples=0 -> phase_valid never asserts; done=1 on the cycle after start; busy stays 0.
- Abort/ignore: start pulsed again mid-burst -> no restart, sequence unchanged. abort after 2 handshakes -> valid low next cycle, no done pulse; a new start is then accepted normally.
